// File: rtl/bolme_denetleyici_pkg.sv
// Shared types and constants for the divide controller: operation codes,
// controller states and the latched request payload.
package bolme_denetleyici_pkg;

   localparam int unsigned VERI_W  = 32;
   localparam int unsigned ISLEM_W = 2;

   localparam logic [ISLEM_W-1:0] BOLME_DIVU = 2'b00;
   localparam logic [ISLEM_W-1:0] BOLME_REMU = 2'b01;
   localparam logic [ISLEM_W-1:0] BOLME_DIV  = 2'b10;
   localparam logic [ISLEM_W-1:0] BOLME_REM  = 2'b11;

   typedef enum logic [1:0] {
      DENETLEYICI_BOSTA   = 2'd0,
      DENETLEYICI_BOLUYOR = 2'd1,
      DENETLEYICI_SONUC   = 2'd2
   } durum_t;

   typedef struct packed {
      logic [ISLEM_W-1:0] islem;
      logic [VERI_W-1:0]  bolunen;
      logic [VERI_W-1:0]  bolen;
   } bolme_istek_t;

   // Signed operations carry a 1 in the upper opcode bit.
   function automatic logic isaretli(input logic [ISLEM_W-1:0] islem);
      return islem[1];
   endfunction

   // Remainder operations carry a 1 in the lower opcode bit.
   function automatic logic kalan_mi(input logic [ISLEM_W-1:0] islem);
      return islem[0];
   endfunction

endpackage

// File: rtl/bolme_hizli_yol.sv
// Fixed-result bypass for divide-by-zero and signed overflow; everything
// else is left to the iterative divider.
module bolme_hizli_yol
   import bolme_denetleyici_pkg::*;
(
   input  logic [ISLEM_W-1:0] islem,
   input  logic [VERI_W-1:0]  bolunen,
   input  logic [VERI_W-1:0]  bolen,
   output logic               hizli_gecerli,
   output logic [VERI_W-1:0]  hizli_sonuc
);

   localparam logic [VERI_W-1:0] EN_KUCUK = {1'b1, {(VERI_W-1){1'b0}}};

   always_comb begin
      hizli_gecerli = 1'b0;
      hizli_sonuc   = '0;
      if (bolen == '0) begin
         hizli_gecerli = 1'b1;
         hizli_sonuc   = kalan_mi(islem) ? bolunen : '1;
      end else if (isaretli(islem) && bolunen == EN_KUCUK && bolen == '1) begin
         hizli_gecerli = 1'b1;
         hizli_sonuc   = kalan_mi(islem) ? '0 : EN_KUCUK;
      end
   end

endmodule

// File: rtl/bolme_denetleyici.sv
// Execute-stage divide controller: accepts DIVU/REMU/DIV/REM requests,
// bypasses trivial cases, reuses the last result and sequences the divider.
module bolme_denetleyici
   import bolme_denetleyici_pkg::*;
#(
   parameter int unsigned ZAMAN_ASIMI    = 64,
   parameter int unsigned ONBELLEK_AKTIF = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               temizle_i,
   input  logic               istek_gecerli_i,
   output logic               istek_hazir_o,
   input  logic [ISLEM_W-1:0] islem_i,
   input  logic [VERI_W-1:0]  bolunen_i,
   input  logic [VERI_W-1:0]  bolen_i,
   output logic               sonuc_gecerli_o,
   input  logic               sonuc_hazir_i,
   output logic [VERI_W-1:0]  sonuc_o,
   output logic               hata_o,
   output logic               bolme_basla_o,
   output logic [ISLEM_W-1:0] bolme_islem_o,
   output logic [VERI_W-1:0]  bolme_bolunen_o,
   output logic [VERI_W-1:0]  bolme_bolen_o,
   input  logic [VERI_W-1:0]  bolme_sonuc_i,
   input  logic               bolme_bitti_i
);

   localparam int unsigned SAYAC_W = $clog2(ZAMAN_ASIMI + 1);

   durum_t              durum_q, durum_d;
   bolme_istek_t        istek_q, istek_d, gelen;
   logic [VERI_W-1:0]   sonuc_q, sonuc_d;
   logic                gecerli_q, gecerli_d;
   logic                basla_q, basla_d;
   logic                hata_q, hata_d;
   logic [SAYAC_W-1:0]  sayac_q, sayac_d;
   logic                onb_gecerli_q;
   bolme_istek_t        onb_istek_q;
   logic [VERI_W-1:0]   onb_sonuc_q;
   logic                onb_yaz;
   logic                kabul;
   logic                isabet;
   logic                hizli_gecerli;
   logic [VERI_W-1:0]   hizli_sonuc;

   assign gelen = '{islem: islem_i, bolunen: bolunen_i, bolen: bolen_i};

   bolme_hizli_yol u_hizli_yol (
      .islem         (islem_i),
      .bolunen       (bolunen_i),
      .bolen         (bolen_i),
      .hizli_gecerli (hizli_gecerli),
      .hizli_sonuc   (hizli_sonuc)
   );

   assign istek_hazir_o = (durum_q == DENETLEYICI_BOSTA) ||
                          (durum_q == DENETLEYICI_SONUC && sonuc_hazir_i);
   assign kabul  = istek_gecerli_i && istek_hazir_o && !temizle_i;
   assign isabet = (ONBELLEK_AKTIF != 0) && onb_gecerli_q && (onb_istek_q == gelen);

   // Next-state and registered-output logic; flush overrides everything.
   always_comb begin
      durum_d   = durum_q;
      istek_d   = istek_q;
      sonuc_d   = sonuc_q;
      gecerli_d = gecerli_q;
      basla_d   = basla_q;
      hata_d    = 1'b0;
      sayac_d   = sayac_q;
      onb_yaz   = 1'b0;
      if (temizle_i) begin
         durum_d   = DENETLEYICI_BOSTA;
         gecerli_d = 1'b0;
         basla_d   = 1'b0;
      end else begin
         case (durum_q)
            DENETLEYICI_BOSTA, DENETLEYICI_SONUC: begin
               if (durum_q == DENETLEYICI_SONUC && sonuc_hazir_i) begin
                  durum_d   = DENETLEYICI_BOSTA;
                  gecerli_d = 1'b0;
               end
               if (kabul) begin
                  istek_d = gelen;
                  sayac_d = '0;
                  if (hizli_gecerli) begin
                     sonuc_d   = hizli_sonuc;
                     gecerli_d = 1'b1;
                     durum_d   = DENETLEYICI_SONUC;
                  end else if (isabet) begin
                     sonuc_d   = onb_sonuc_q;
                     gecerli_d = 1'b1;
                     durum_d   = DENETLEYICI_SONUC;
                  end else begin
                     basla_d   = 1'b1;
                     gecerli_d = 1'b0;
                     durum_d   = DENETLEYICI_BOLUYOR;
                  end
               end
            end
            DENETLEYICI_BOLUYOR: begin
               if (basla_q && bolme_bitti_i) begin
                  sonuc_d   = bolme_sonuc_i;
                  onb_yaz   = 1'b1;
                  gecerli_d = 1'b1;
                  basla_d   = 1'b0;
                  durum_d   = DENETLEYICI_SONUC;
               end else if (sayac_q == SAYAC_W'(ZAMAN_ASIMI - 1)) begin
                  sonuc_d   = '0;
                  hata_d    = 1'b1;
                  gecerli_d = 1'b1;
                  basla_d   = 1'b0;
                  durum_d   = DENETLEYICI_SONUC;
               end else begin
                  sayac_d = sayac_q + SAYAC_W'(1);
               end
            end
            default: begin
               durum_d   = DENETLEYICI_BOSTA;
               gecerli_d = 1'b0;
               basla_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         durum_q   <= DENETLEYICI_BOSTA;
         istek_q   <= '0;
         sonuc_q   <= '0;
         gecerli_q <= 1'b0;
         basla_q   <= 1'b0;
         hata_q    <= 1'b0;
         sayac_q   <= '0;
      end else begin
         durum_q   <= durum_d;
         istek_q   <= istek_d;
         sonuc_q   <= sonuc_d;
         gecerli_q <= gecerli_d;
         basla_q   <= basla_d;
         hata_q    <= hata_d;
         sayac_q   <= sayac_d;
      end
   end

   // Last-result cache, written only on a genuine divider completion.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         onb_gecerli_q <= 1'b0;
         onb_istek_q   <= '0;
         onb_sonuc_q   <= '0;
      end else if (onb_yaz) begin
         onb_gecerli_q <= 1'b1;
         onb_istek_q   <= istek_q;
         onb_sonuc_q   <= bolme_sonuc_i;
      end
   end

   assign sonuc_gecerli_o = gecerli_q;
   assign sonuc_o         = sonuc_q;
   assign hata_o          = hata_q;
   assign bolme_basla_o   = basla_q;
   assign bolme_islem_o   = istek_q.islem;
   assign bolme_bolunen_o = istek_q.bolunen;
   assign bolme_bolen_o   = istek_q.bolen;

endmodule

// File: tb/tb_bolme_denetleyici.sv
// Scoreboard bench for bolme_denetleyici with a 35-cycle divider model.
module tb_bolme_denetleyici;
   import bolme_denetleyici_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        temizle_i = 1'b0;
   logic        istek_gecerli_i = 1'b0;
   logic        istek_hazir_o;
   logic [1:0]  islem_i = '0;
   logic [31:0] bolunen_i = '0;
   logic [31:0] bolen_i = '0;
   logic        sonuc_gecerli_o;
   logic        sonuc_hazir_i = 1'b1;
   logic [31:0] sonuc_o;
   logic        hata_o;
   logic        bolme_basla_o;
   logic [1:0]  bolme_islem_o;
   logic [31:0] bolme_bolunen_o;
   logic [31:0] bolme_bolen_o;
   logic [31:0] bolme_sonuc_i;
   logic        bolme_bitti_i;

   typedef struct {
      logic [31:0] sonuc;
      int          gecikme;
      logic        hata;
      int          kabul;
   } sb_t;

   sb_t  sb_q[$];
   sb_t  e;
   int   toplam = 0;
   int   bad = 0;
   int   cyc = 0;
   int   basla_say = 0;
   int   hata_say = 0;
   int   ilk_cyc = 0;
   logic ilk_hata = 1'b0;
   bit   yeni = 1'b1;
   bit   takili = 1'b0;
   int   bolme_cnt = 0;

   bolme_denetleyici #(.ZAMAN_ASIMI(64), .ONBELLEK_AKTIF(1)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .temizle_i(temizle_i),
      .istek_gecerli_i(istek_gecerli_i), .istek_hazir_o(istek_hazir_o),
      .islem_i(islem_i), .bolunen_i(bolunen_i), .bolen_i(bolen_i),
      .sonuc_gecerli_o(sonuc_gecerli_o), .sonuc_hazir_i(sonuc_hazir_i),
      .sonuc_o(sonuc_o), .hata_o(hata_o), .bolme_basla_o(bolme_basla_o),
      .bolme_islem_o(bolme_islem_o), .bolme_bolunen_o(bolme_bolunen_o),
      .bolme_bolen_o(bolme_bolen_o), .bolme_sonuc_i(bolme_sonuc_i),
      .bolme_bitti_i(bolme_bitti_i)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Divider model: done on the 35th basla-high cycle, restarts when basla drops.
   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) bolme_cnt <= 0;
      else if (!bolme_basla_o) bolme_cnt <= 0;
      else bolme_cnt <= bolme_cnt + 1;
   end
   assign bolme_bitti_i = bolme_basla_o && (bolme_cnt == 34) && !takili;
   always_comb begin
      bolme_sonuc_i = '0;
      if (bolme_basla_o && bolme_bolen_o != '0) begin
         case (bolme_islem_o)
            BOLME_DIVU: bolme_sonuc_i = bolme_bolunen_o / bolme_bolen_o;
            BOLME_REMU: bolme_sonuc_i = bolme_bolunen_o % bolme_bolen_o;
            BOLME_DIV:  bolme_sonuc_i = 32'($signed(bolme_bolunen_o) / $signed(bolme_bolen_o));
            default:    bolme_sonuc_i = 32'($signed(bolme_bolunen_o) % $signed(bolme_bolen_o));
         endcase
      end
   end

   always @(negedge clk_i) begin
      if (bolme_basla_o) basla_say++;
      if (hata_o) hata_say++;
   end

   task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
      toplam++;
      if (gercek !== beklenen) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (cyc %0d)", ad, gercek, beklenen, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on every consumed result.
   always @(negedge clk_i) begin
      if (rst_i || !sonuc_gecerli_o) begin
         yeni = 1'b1;
      end else begin
         if (yeni) begin
            ilk_cyc  = cyc;
            ilk_hata = hata_o;
            yeni     = 1'b0;
         end
         if (sonuc_hazir_i) begin
            if (sb_q.size() == 0) begin
               toplam++;
               bad++;
               $display("FAIL unexpected_result: got=%h expected=none", sonuc_o);
            end else begin
               e = sb_q.pop_front();
               kontrol("sonuc", sonuc_o, e.sonuc);
               kontrol("hata", 32'(ilk_hata), 32'(e.hata));
               kontrol("latency", 32'(ilk_cyc - e.kabul), 32'(e.gecikme));
            end
            yeni = 1'b1;
         end
      end
   end

   // Call just after a rising edge; returns just after the accepting edge.
   task automatic istek(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit kaydet, input logic [31:0] bek, input int gec, input logic bek_hata);
      bit ok = 1'b0;
      sb_t s;
      istek_gecerli_i = 1'b1;
      islem_i = op;
      bolunen_i = a;
      bolen_i = b;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_i);
         if (istek_hazir_o && !temizle_i) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         toplam++;
         bad++;
         $display("FAIL accept_timeout: got=not_ready expected=ready");
      end else if (kaydet) begin
         s.sonuc = bek;
         s.gecikme = gec;
         s.hata = bek_hata;
         s.kabul = cyc;
         sb_q.push_back(s);
      end
      basla_say = 0;
      @(posedge clk_i);
      #1 istek_gecerli_i = 1'b0;
   endtask

   task automatic bekle_sonuc(input int basla_bek);
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_i);
         if (sonuc_gecerli_o) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         toplam++;
         bad++;
         $display("FAIL result_timeout: got=no_valid expected=valid");
      end
      kontrol("basla_cycles", 32'(basla_say), 32'(basla_bek));
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      int h0;
      int gsay;
      repeat (3) @(posedge clk_i);
      #1;
      kontrol("rst_gecerli", 32'(sonuc_gecerli_o), 32'd0);
      kontrol("rst_sonuc", sonuc_o, 32'd0);
      kontrol("rst_basla", 32'(bolme_basla_o), 32'd0);
      kontrol("rst_hata", 32'(hata_o), 32'd0);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;

      // Divider path and cache
      istek(BOLME_DIVU, 32'd100, 32'd7, 1, 32'd14, 36, 0);          bekle_sonuc(35);
      istek(BOLME_DIV, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD, 36, 0); bekle_sonuc(35);
      istek(BOLME_REM, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 36, 0); bekle_sonuc(35);
      istek(BOLME_REM, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 1, 0);  bekle_sonuc(0);

      // Fixed-result bypass
      istek(BOLME_DIVU, 32'h1234, 32'd0, 1, 32'hFFFF_FFFF, 1, 0);      bekle_sonuc(0);
      istek(BOLME_REMU, 32'h1234, 32'd0, 1, 32'h1234, 1, 0);           bekle_sonuc(0);
      istek(BOLME_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1, 0); bekle_sonuc(0);
      istek(BOLME_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 1, 0);  bekle_sonuc(0);

      // Flush in the 10th basla cycle
      istek(BOLME_DIVU, 32'd1000, 32'd3, 0, 32'd0, 0, 0);
      repeat (9) @(posedge clk_i);
      #1 temizle_i = 1'b1;
      @(posedge clk_i);
      #1 temizle_i = 1'b0;
      @(negedge clk_i);
      kontrol("flush_basla", 32'(bolme_basla_o), 32'd0);
      gsay = 0;
      for (int i = 0; i < 40; i++) begin
         if (sonuc_gecerli_o) gsay++;
         @(negedge clk_i);
      end
      kontrol("flush_no_valid", 32'(gsay), 32'd0);
      @(posedge clk_i);
      #1;
      istek(BOLME_DIVU, 32'd1000, 32'd3, 1, 32'd333, 36, 0);           bekle_sonuc(35);

      // Result held while not consumed, then back-to-back acceptance
      sonuc_hazir_i = 1'b0;
      istek(BOLME_DIVU, 32'h1234, 32'd0, 1, 32'hFFFF_FFFF, 1, 0);      bekle_sonuc(0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         kontrol("hold_valid", 32'(sonuc_gecerli_o), 32'd1);
         kontrol("hold_sonuc", sonuc_o, 32'hFFFF_FFFF);
      end
      @(posedge clk_i);
      #1 sonuc_hazir_i = 1'b1;
      istek(BOLME_REMU, 32'h55, 32'd0, 1, 32'h55, 1, 0);               bekle_sonuc(0);

      // Timeout with a stuck divider; the aborted result must not be cached
      takili = 1'b1;
      h0 = hata_say;
      istek(BOLME_DIVU, 32'd50, 32'd5, 1, 32'd0, 65, 1);               bekle_sonuc(64);
      repeat (3) @(negedge clk_i);
      kontrol("hata_pulses", 32'(hata_say - h0), 32'd1);
      @(posedge clk_i);
      #1 takili = 1'b0;
      istek(BOLME_DIVU, 32'd50, 32'd5, 1, 32'd10, 36, 0);              bekle_sonuc(35);

      // Async reset mid-divide clears outputs and the cache
      istek(BOLME_DIVU, 32'd9, 32'd3, 0, 32'd0, 0, 0);
      repeat (5) @(negedge clk_i);
      #2 rst_i = 1'b1;
      #1;
      kontrol("arst_basla", 32'(bolme_basla_o), 32'd0);
      kontrol("arst_gecerli", 32'(sonuc_gecerli_o), 32'd0);
      kontrol("arst_bolunen", bolme_bolunen_o, 32'd0);
      kontrol("arst_bolen", bolme_bolen_o, 32'd0);
      kontrol("arst_islem", 32'(bolme_islem_o), 32'd0);
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      istek(BOLME_DIVU, 32'd50, 32'd5, 1, 32'd10, 36, 0);              bekle_sonuc(35);

      repeat (3) @(posedge clk_i);
      kontrol("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", toplam, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got=running expected=finished");
      $fatal(1, "global timeout");
   end

endmodule
